config_scanner: RTL and testbench
=================================

Name: config_scanner

Overview:
- Parametrised successor to the fixed-map control-register poller.
- Scans a configurable window of words from port B of the dual-port config BRAM into a shadow register file, then performs one clear-on-read write-back and one status write.
- Commits the whole snapshot to the outputs atomically, once per scan, so downstream blocks never see a mixed old/new set.
- Sits between the config BRAM (CPU on port A) and the modulation/sequence/silencer consumers; BRAM latency is a parameter.

Parameters:
DATA_WIDTH, 16, BRAM word width
ADDR_WIDTH, 6, BRAM port-B address width
NUM_REGS, 21, words scanned, addresses 0..NUM_REGS-1; must be 1..2**ADDR_WIDTH
READ_LATENCY, 1, BRAM port-B read latency in cycles, 1..3
CLR_ADDR, 6'h13, clear-on-read word address; must be < NUM_REGS
STATUS_ADDR, 6'h01, status write-back address; must be < 2**ADDR_WIDTH

Ports:
CLK  in  1  system clock; BRAM port-B clock
RST_N  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low
BRAM_ADDR  out  ADDR_WIDTH  port-B address
BRAM_WE  out  1  port-B write enable
BRAM_DIN  out  DATA_WIDTH  port-B write data
BRAM_DOUT  in  DATA_WIDTH  port-B read data, valid READ_LATENCY cycles after address
STATUS_IN  in  DATA_WIDTH  status word (thermo, fan etc.), sampled in STATUS state
HOLD  in  1  when high in COMMIT state, the commit is skipped
REGS_OUT  out  NUM_REGS*DATA_WIDTH  committed snapshot; word k at bits [k*DATA_WIDTH +: DATA_WIDTH]
COMMIT  out  1  one-cycle pulse, coincident with the first cycle of new REGS_OUT
SCAN_CNT  out  16  count of completed commits, wraps at 16'hFFFF->0

Behaviour:
- Reset (RST_N low, async): all outputs and the shadow file go to 0; BRAM_ADDR=0; state=READ with index 0.
  - The first READ cycle is the first CLK edge after deassertion.
  - Reset mid-scan abandons the scan: no commit, no pending write completes.
- States: READ -> DRAIN -> CLEAR -> STATUS -> COMMIT -> READ.
- READ:
  - Lasts NUM_REGS cycles; on the k-th cycle BRAM_ADDR=k, BRAM_WE=0, BRAM_DIN=0.
  - A valid/index pipeline of depth READ_LATENCY tags each issued address.
  - BRAM_DOUT is written into shadow[index] when the tag emerges.
- DRAIN:
  - Lasts READ_LATENCY cycles; BRAM_WE=0; BRAM_ADDR holds the last value.
  - Remaining tagged data is captured during this state.
  - Capture must complete before CLEAR evaluates shadow.
- CLEAR:
  - 1 cycle; BRAM_ADDR=CLR_ADDR, BRAM_DIN=0.
  - BRAM_WE=1 only if shadow[CLR_ADDR]!=0; otherwise 0.
  - The shadow keeps the read value, so a nonzero clear word appears in exactly one commit.
  - A CPU write landing between the read and the clear is lost (accepted).
- STATUS: 1 cycle; BRAM_ADDR=STATUS_ADDR, BRAM_WE=1, BRAM_DIN=STATUS_IN as sampled that cycle.
- COMMIT: 1 cycle; BRAM_WE=0.
  - HOLD=0: REGS_OUT<=shadow, COMMIT<=1, SCAN_CNT<=SCAN_CNT+1, all registered; visible in the following cycle, together with that cycle's READ index 0.
  - HOLD=1: REGS_OUT, COMMIT and SCAN_CNT are unchanged; the scan still continues.
- Scan period: NUM_REGS+READ_LATENCY+3 cycles (25 at defaults). COMMIT is low in every other cycle.
- If STATUS_ADDR<NUM_REGS, the next scan reads back the value written.
- BRAM_WE is high only in CLEAR or STATUS.
- All outputs are registered; there is no combinational path from any input to any output.

Test Plan:
1. Defaults; preload word k = 16'hA000+k (k=0..20); release reset.
   - First COMMIT pulse at cycle 25.
   - REGS_OUT word 5 = 16'hA005, word 20 = 16'hA014.
   - SCAN_CNT = 1.
2. Word 0x13 = 16'h0003.
   - CLEAR state shows BRAM_WE=1, ADDR=0x13, DIN=0.
   - First commit has word 0x13 = 3; the next commit has 0.
   - With word 0x13 = 0, BRAM_WE stays low during CLEAR.
3. STATUS_IN = 16'h0001.
   - STATUS cycle writes addr 0x01 = 0001.
   - The second commit shows word 1 = 16'h0001.
4. READ_LATENCY=3, NUM_REGS=4, pattern 16'h1111*k.
   - Period 10 cycles.
   - REGS_OUT = {3333,2222,1111,0000}; no index skew.
5. HOLD=1 across two COMMIT states while the BRAM contents change.
   - No COMMIT pulse; REGS_OUT and SCAN_CNT frozen.
   - Release HOLD: next commit carries the new data; SCAN_CNT +1.
6. Assert RST_N low during DRAIN.
   - Outputs go to 0 immediately (async); no BRAM write issued.
   - After release, the scan restarts at index 0.

Source files
------------

// File: rtl/config_scanner.sv
// config_scanner: copies BRAM words 0..NUM_REGS-1 into a shadow file, clears one word,
// writes status back, then commits the snapshot to REGS_OUT in a single cycle.
// Ports: CLK, RST_N (async, active-low); BRAM_ADDR/WE/DIN/DOUT = BRAM port B;
// STATUS_IN and HOLD inputs; REGS_OUT, COMMIT pulse and SCAN_CNT outputs.
module config_scanner #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_REGS = 21,
  parameter int READ_LATENCY = 1,
  parameter logic [ADDR_WIDTH-1:0] CLR_ADDR = 6'h13,
  parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR = 6'h01
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  output logic [ADDR_WIDTH-1:0]          BRAM_ADDR,
  output logic                           BRAM_WE,
  output logic [DATA_WIDTH-1:0]          BRAM_DIN,
  input  logic [DATA_WIDTH-1:0]          BRAM_DOUT,
  input  logic [DATA_WIDTH-1:0]          STATUS_IN,
  input  logic                           HOLD,
  output logic [NUM_REGS*DATA_WIDTH-1:0] REGS_OUT,
  output logic                           COMMIT,
  output logic [15:0]                    SCAN_CNT
);

  localparam int CLR_I = int'(CLR_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [1:0] LAST_DRN = 2'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    S_READ,
    S_DRAIN,
    S_CLEAR,
    S_STATUS,
    S_COMMIT
  } state_t;

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [ADDR_WIDTH-1:0]          r_idx;
  logic [ADDR_WIDTH-1:0]          w_idx_nxt;
  logic [1:0]                     r_dcnt;
  logic [1:0]                     w_dcnt_nxt;
  logic [ADDR_WIDTH-1:0]          r_addr;
  logic [ADDR_WIDTH-1:0]          w_addr_nxt;
  logic                           r_we;
  logic                           w_we_nxt;
  logic [DATA_WIDTH-1:0]          r_din;
  logic [DATA_WIDTH-1:0]          w_din_nxt;
  logic                           w_commit_go;

  logic [DATA_WIDTH-1:0]          r_shadow [NUM_REGS];
  logic [READ_LATENCY-1:0]        r_pv;
  logic [ADDR_WIDTH-1:0]          r_pi [READ_LATENCY];
  logic                           w_cap;
  logic [ADDR_WIDTH-1:0]          w_cap_idx;
  logic [DATA_WIDTH-1:0]          w_clr_word;

  logic [NUM_REGS*DATA_WIDTH-1:0] r_regs;
  logic                           r_commit;
  logic [15:0]                    r_cnt;

  assign BRAM_ADDR = r_addr;
  assign BRAM_WE   = r_we;
  assign BRAM_DIN  = r_din;
  assign REGS_OUT  = r_regs;
  assign COMMIT    = r_commit;
  assign SCAN_CNT  = r_cnt;

  assign w_cap     = r_pv[READ_LATENCY-1];
  assign w_cap_idx = r_pi[READ_LATENCY-1];

  // The clear decision is registered on the same edge that may capture
  // the clear word, so look through the capture port in that case.
  assign w_clr_word = (w_cap && w_cap_idx == CLR_ADDR) ?
                      BRAM_DOUT : r_shadow[CLR_I];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_READ;
      r_idx   <= '0;
      r_dcnt  <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_din   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_dcnt  <= w_dcnt_nxt;
      r_addr  <= w_addr_nxt;
      r_we    <= w_we_nxt;
      r_din   <= w_din_nxt;
    end
  end

  // Port-B outputs are computed for the state being entered, so the
  // registered values line up with the state they belong to.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_dcnt_nxt  = r_dcnt;
    w_addr_nxt  = r_addr;
    w_we_nxt    = 1'b0;
    w_din_nxt   = '0;
    w_commit_go = 1'b0;
    unique case (r_state)
      S_READ: begin
        if (r_idx == LAST_IDX) begin
          w_state_nxt = S_DRAIN;
          w_dcnt_nxt  = '0;
        end else begin
          w_idx_nxt  = r_idx + 1'b1;
          w_addr_nxt = r_idx + 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_dcnt == LAST_DRN) begin
          w_state_nxt = S_CLEAR;
          w_addr_nxt  = CLR_ADDR;
          w_we_nxt    = (w_clr_word != '0);
        end else begin
          w_dcnt_nxt = r_dcnt + 1'b1;
        end
      end
      S_CLEAR: begin
        w_state_nxt = S_STATUS;
        w_addr_nxt  = STATUS_ADDR;
        w_we_nxt    = 1'b1;
        w_din_nxt   = STATUS_IN;
      end
      S_STATUS: begin
        w_state_nxt = S_COMMIT;
      end
      S_COMMIT: begin
        w_state_nxt = S_READ;
        w_idx_nxt   = '0;
        w_addr_nxt  = '0;
        w_commit_go = !HOLD;
      end
      default: begin
        w_state_nxt = S_READ;
        w_idx_nxt   = '0;
        w_addr_nxt  = '0;
      end
    endcase
  end

  // Tag pipeline: each issued index travels alongside its read data.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pv <= '0;
      for (int i = 0; i < READ_LATENCY; i++) r_pi[i] <= '0;
      for (int k = 0; k < NUM_REGS; k++) r_shadow[k] <= '0;
    end else begin
      r_pv[0] <= (r_state == S_READ);
      r_pi[0] <= r_idx;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pi[i] <= r_pi[i-1];
      end
      for (int k = 0; k < NUM_REGS; k++) begin
        if (w_cap && w_cap_idx == ADDR_WIDTH'(k)) r_shadow[k] <= BRAM_DOUT;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_regs   <= '0;
      r_commit <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_commit <= w_commit_go;
      if (w_commit_go) begin
        r_cnt <= r_cnt + 16'd1;
        for (int k = 0; k < NUM_REGS; k++) begin
          r_regs[k*DATA_WIDTH +: DATA_WIDTH] <= r_shadow[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_config_scanner.sv
// tb_config_scanner: two scanner instances (defaults, and latency 3 / 4 words)
// driven by BRAM models and checked against a scan-level reference model.
module tb_config_scanner;

  localparam int DW = 16;
  localparam int AW = 6;
  localparam int NA = 21;
  localparam int LA = 1;
  localparam int TA = NA + LA + 3;
  localparam int NB = 4;
  localparam int LB = 3;
  localparam int TB = NB + LB + 3;
  localparam int W  = NA * DW;
  localparam logic [AW-1:0] CLR_A = 6'h13;
  localparam logic [AW-1:0] ST_A  = 6'h01;
  localparam logic [AW-1:0] ST_B  = 6'h3F;
  localparam logic [NB*DW-1:0] B_PAT = 64'h3333_2222_1111_0000;
  localparam logic [DW-1:0] B_ST  = 16'h0BEE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]    a_addr;
  logic             a_we;
  logic [DW-1:0]    a_din;
  logic [DW-1:0]    a_dout;
  logic [DW-1:0]    a_status = '0;
  logic             a_hold = 1'b0;
  logic [NA*DW-1:0] a_regs;
  logic             a_commit;
  logic [15:0]      a_cnt;

  logic [AW-1:0]    b_addr;
  logic             b_we;
  logic [DW-1:0]    b_din;
  logic [DW-1:0]    b_dout;
  logic [NB*DW-1:0] b_regs;
  logic             b_commit;
  logic [15:0]      b_cnt;

  config_scanner u_a (
    .CLK(clk), .RST_N(rst_n),
    .BRAM_ADDR(a_addr), .BRAM_WE(a_we), .BRAM_DIN(a_din),
    .BRAM_DOUT(a_dout), .STATUS_IN(a_status), .HOLD(a_hold),
    .REGS_OUT(a_regs), .COMMIT(a_commit), .SCAN_CNT(a_cnt)
  );

  config_scanner #(
    .READ_LATENCY(LB), .NUM_REGS(NB),
    .CLR_ADDR(6'h00), .STATUS_ADDR(ST_B)
  ) u_b (
    .CLK(clk), .RST_N(rst_n),
    .BRAM_ADDR(b_addr), .BRAM_WE(b_we), .BRAM_DIN(b_din),
    .BRAM_DOUT(b_dout), .STATUS_IN(B_ST), .HOLD(1'b0),
    .REGS_OUT(b_regs), .COMMIT(b_commit), .SCAN_CNT(b_cnt)
  );

  // BRAM port-B models; a bulk load stands in for CPU port-A traffic.
  logic [DW-1:0] mem_a [64];
  logic [DW-1:0] img_a [64];
  logic          a_ld = 1'b0;
  logic [DW-1:0] mem_b [64];
  logic [DW-1:0] img_b [64];
  logic          b_ld = 1'b0;
  logic [DW-1:0] b_p0;
  logic [DW-1:0] b_p1;

  always @(posedge clk) begin
    if (a_ld) for (int i = 0; i < 64; i++) mem_a[i] <= img_a[i];
    if (a_we) mem_a[a_addr] <= a_din;
    a_dout <= mem_a[a_addr];
  end

  always @(posedge clk) begin
    if (b_ld) for (int i = 0; i < 64; i++) mem_b[i] <= img_b[i];
    if (b_we) mem_b[b_addr] <= b_din;
    b_p0   <= mem_b[b_addr];
    b_p1   <= b_p0;
    b_dout <= b_p1;
  end

  int n_chk = 0;
  int n_err = 0;
  int e = 0;
  int pa = 0;
  int pb = 0;
  int n_pulse_a = 0;

  logic [DW-1:0] ref_a [64];
  logic [DW-1:0] snap_a [64];
  logic [DW-1:0] exp_regs_a [NA];
  logic [15:0]   exp_cnt_a = '0;
  logic          exp_pulse_a = 1'b0;
  logic [15:0]   exp_cnt_b = '0;
  logic          scan_hold = 1'b0;
  logic [DW-1:0] scan_st = '0;
  logic          scan_ld = 1'b0;
  logic          clr_we = 1'b0;
  logic [15:0]   saved_cnt;

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pack_a();
    logic [W-1:0] v;
    for (int k = 0; k < NA; k++) v[k*DW +: DW] = exp_regs_a[k];
    return v;
  endfunction

  // End of a scan: commit what was read, then apply the clear, any
  // port-A load and the status write, giving next scan's view.
  task automatic model_scan_end();
    exp_pulse_a = !scan_hold;
    if (!scan_hold) begin
      for (int k = 0; k < NA; k++) exp_regs_a[k] = snap_a[k];
      exp_cnt_a = exp_cnt_a + 16'd1;
    end
    ref_a[CLR_A] = '0;
    if (scan_ld) for (int i = 0; i < 64; i++) ref_a[i] = img_a[i];
    ref_a[ST_A] = scan_st;
    for (int i = 0; i < 64; i++) snap_a[i] = ref_a[i];
  endtask

  task automatic check_a();
    chk("a_commit", W'(a_commit), W'((pa == 0) && exp_pulse_a));
    chk("a_cnt", W'(a_cnt), W'(exp_cnt_a));
    chk("a_regs", a_regs, pack_a());
    if (pa < NA) begin
      chk("a_addr_rd", W'(a_addr), W'(pa));
      chk("a_we_rd", W'(a_we), '0);
      chk("a_din_rd", W'(a_din), '0);
    end else if (pa < NA + LA) begin
      chk("a_addr_drn", W'(a_addr), W'(NA - 1));
      chk("a_we_drn", W'(a_we), '0);
    end else if (pa == NA + LA) begin
      chk("a_addr_clr", W'(a_addr), W'(CLR_A));
      chk("a_we_clr", W'(a_we), W'(snap_a[CLR_A] != '0));
      chk("a_din_clr", W'(a_din), '0);
    end else if (pa == NA + LA + 1) begin
      chk("a_addr_st", W'(a_addr), W'(ST_A));
      chk("a_we_st", W'(a_we), W'(1'b1));
      chk("a_din_st", W'(a_din), W'(scan_st));
    end else begin
      chk("a_we_cm", W'(a_we), '0);
    end
  endtask

  task automatic check_b();
    chk("b_commit", W'(b_commit), W'(pb == 0));
    chk("b_cnt", W'(b_cnt), W'(exp_cnt_b));
    chk("b_regs", W'(b_regs), (exp_cnt_b != 0) ? W'(B_PAT) : '0);
    if (pb < NB) begin
      chk("b_addr_rd", W'(b_addr), W'(pb));
      chk("b_we_rd", W'(b_we), '0);
    end else if (pb < NB + LB) begin
      chk("b_addr_drn", W'(b_addr), W'(NB - 1));
      chk("b_we_drn", W'(b_we), '0);
    end else if (pb == NB + LB) begin
      chk("b_addr_clr", W'(b_addr), '0);
      chk("b_we_clr", W'(b_we), '0);
    end else if (pb == NB + LB + 1) begin
      chk("b_addr_st", W'(b_addr), W'(ST_B));
      chk("b_we_st", W'(b_we), W'(1'b1));
      chk("b_din_st", W'(b_din), W'(B_ST));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    e++;
    pa = e % TA;
    pb = e % TB;
    if (pa == 0) model_scan_end();
    if (pb == 0) exp_cnt_b = exp_cnt_b + 16'd1;
    check_a();
    check_b();
    if (a_commit) n_pulse_a++;
    if (pa == NA + LA) clr_we = a_we;
    a_ld = (pa == NA + LA + 1) && scan_ld;
  endtask

  task automatic scan(input logic h, input logic [DW-1:0] st,
                      input logic ld);
    a_hold = h;
    a_status = st;
    scan_hold = h;
    scan_st = st;
    scan_ld = ld;
    repeat (TA) tick();
  endtask

  task automatic rand_img();
    for (int i = 0; i < 64; i++) img_a[i] = DW'($urandom);
  endtask

  // Runs into the first DRAIN cycle, then pulls reset asynchronously.
  task automatic scan_rst();
    a_hold = 1'b0;
    scan_hold = 1'b0;
    scan_ld = 1'b0;
    repeat (NA) tick();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_a_regs", a_regs, '0);
    chk("rst_a_cnt", W'(a_cnt), '0);
    chk("rst_a_commit", W'(a_commit), '0);
    chk("rst_a_we", W'(a_we), '0);
    chk("rst_a_addr", W'(a_addr), '0);
    chk("rst_b_regs", W'(b_regs), '0);
    chk("rst_b_we", W'(b_we), '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    e = 0;
    exp_cnt_a = '0;
    exp_pulse_a = 1'b0;
    exp_cnt_b = '0;
    for (int k = 0; k < NA; k++) exp_regs_a[k] = '0;
    for (int i = 0; i < 64; i++) snap_a[i] = ref_a[i];
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      img_a[i] = (i < NA) ? (16'hA000 + DW'(i)) : DW'($urandom);
      img_b[i] = (i < NB) ? (16'h1111 * DW'(i)) : '0;
    end
    for (int k = 0; k < NA; k++) exp_regs_a[k] = '0;
    a_ld = 1'b1;
    b_ld = 1'b1;
    @(negedge clk);
    @(negedge clk);
    a_ld = 1'b0;
    b_ld = 1'b0;
    for (int i = 0; i < 64; i++) begin
      ref_a[i] = img_a[i];
      snap_a[i] = img_a[i];
    end
    rst_n = 1'b1;

    rand_img();
    img_a[CLR_A] = 16'h0003;
    scan(1'b0, 16'h0001, 1'b1);
    chk("t1_pulse", W'(a_commit), W'(1'b1));
    chk("t1_word5", W'(a_regs[5*DW +: DW]), W'(16'hA005));
    chk("t1_word20", W'(a_regs[20*DW +: DW]), W'(16'hA014));
    chk("t1_cnt", W'(a_cnt), W'(16'd1));
    chk("t1_clr_we", W'(clr_we), W'(1'b1));

    scan(1'b0, DW'($urandom), 1'b0);
    chk("t3_word1", W'(a_regs[1*DW +: DW]), W'(16'h0001));
    chk("t2_word13", W'(a_regs[19*DW +: DW]), W'(16'h0003));
    chk("t2_clr_we", W'(clr_we), W'(1'b1));
    scan(1'b0, DW'($urandom), 1'b0);
    chk("t2_cleared", W'(a_regs[19*DW +: DW]), '0);
    chk("t2_clr_idle", W'(clr_we), '0);

    for (int s = 0; s < 6; s++) begin
      rand_img();
      if (s[0]) img_a[CLR_A] = '0;
      scan(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));
    end

    scan(1'b0, DW'($urandom), 1'b0);
    saved_cnt = exp_cnt_a;
    n_pulse_a = 0;
    rand_img();
    scan(1'b1, DW'($urandom), 1'b1);
    rand_img();
    scan(1'b1, DW'($urandom), 1'b1);
    chk("t5_no_pulse", W'(n_pulse_a), '0);
    chk("t5_cnt_frozen", W'(a_cnt), W'(saved_cnt));
    scan(1'b0, DW'($urandom), 1'b0);
    chk("t5_cnt_inc", W'(a_cnt), W'(saved_cnt + 16'd1));
    chk("t5_new_data", W'(a_regs[5*DW +: DW]), W'(img_a[5]));

    rand_img();
    img_a[CLR_A] = 16'h0005;
    scan(1'b0, DW'($urandom), 1'b1);
    scan_rst();
    scan(1'b0, DW'($urandom), 1'b0);
    chk("t6_word13", W'(a_regs[19*DW +: DW]), W'(16'h0005));
    chk("t6_cnt", W'(a_cnt), W'(16'd1));
    scan(1'b0, DW'($urandom), 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
